// File: rtl/note_sequencer_pkg.sv
// Shared constants, state encoding and entry-field helpers for the note sequencer.
package note_sequencer_pkg;

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_REC  = 2'd1;
    localparam logic [1:0] MODE_PLAY = 2'd2;

    localparam int OCT_W  = 3;
    localparam int NOTE_W = 3;

    localparam logic [NOTE_W-1:0] NOTE_REST = 3'd0;

    // FETCH is an internal step of playback and is reported as PLAY on the mode port.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REC   = 2'd1,
        ST_FETCH = 2'd2,
        ST_PLAY  = 2'd3
    } seq_state_t;

    // Entry layout, MSB first: {octave, note, dur}.
    function automatic int entry_w(input int dur_w);
        return OCT_W + NOTE_W + dur_w;
    endfunction

    function automatic int note_lsb(input int dur_w);
        return dur_w;
    endfunction

    function automatic int oct_lsb(input int dur_w);
        return dur_w + NOTE_W;
    endfunction

    function automatic logic [1:0] state_to_mode(input seq_state_t s);
        logic [1:0] m;
        case (s)
            ST_REC:   m = MODE_REC;
            ST_FETCH: m = MODE_PLAY;
            ST_PLAY:  m = MODE_PLAY;
            default:  m = MODE_IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/note_sequencer_ram.sv
// Recording store: single port, synchronous write, registered (1-cycle) read.
// No reset on the array so synthesis maps it to block RAM.
module note_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];

    // Read-first single port: the read data is the old word when writing.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/note_sequencer.sv
// Record/playback controller between the key decoder and the amplifier.
// Records timed {octave, note, duration} events and replays them with the
// original timing; drives the amplifier from live keys or from playback.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DUR_W    = 10,
    parameter int TICK_DIV = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        live_octave,
    input  logic [2:0]        live_note,
    input  logic              cmd_rec,
    input  logic              cmd_play,
    input  logic              cmd_stop,
    input  logic              loop_en,
    output logic [2:0]        out_octave,
    output logic [2:0]        out_note,
    output logic [1:0]        mode,
    output logic [ADDR_W:0]   rec_count,
    output logic              full
);

    localparam int ENTRY_W  = entry_w(DUR_W);
    localparam int NOTE_LSB = note_lsb(DUR_W);
    localparam int OCT_LSB  = oct_lsb(DUR_W);
    localparam int CNT_W    = ADDR_W + 1;
    localparam int DEPTH    = 1 << ADDR_W;
    localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DUR_W-1:0]   DUR_MAX  = {DUR_W{1'b1}};
    localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(TICK_DIV - 1);

    seq_state_t state;
    seq_state_t state_next;

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic [2:0]         cur_octave;
    logic [2:0]         cur_note;
    logic [DUR_W-1:0]   dur;
    logic [DUR_W-1:0]   rem;
    logic [ADDR_W-1:0]  rd_idx;
    logic               fetch_wait;

    logic               ram_we;
    logic [ADDR_W-1:0]  ram_addr;
    logic [ENTRY_W-1:0] ram_wdata;
    logic [ENTRY_W-1:0] ram_rdata;

    // Control strobes decoded by the FSM and consumed by the datapath.
    logic start_rec;
    logic start_play;
    logic advance;
    logic load_entry;

    logic live_chg;
    logic dur_sat;
    logic rec_last;
    logic play_done;
    logic has_next;

    assign tick      = (presc == PRESC_TOP);
    assign live_chg  = ({live_octave, live_note} != {cur_octave, cur_note});
    assign dur_sat   = (dur == DUR_MAX);
    assign rec_last  = (rec_count == CNT_W'(DEPTH - 1));
    assign play_done = (state == ST_PLAY) && tick && (rem <= DUR_W'(1));
    assign has_next  = (({1'b0, rd_idx} + CNT_W'(1)) < rec_count);

    // A zero-length pending event is stored as one tick so it is still audible on replay.
    assign ram_wdata = {cur_octave, cur_note, (dur == '0) ? DUR_W'(1) : dur};
    assign ram_addr  = (state == ST_REC) ? rec_count[ADDR_W-1:0] : rd_idx;
    assign mode      = state_to_mode(state);

    note_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and control strobes; stop outranks rec, rec outranks play.
    always_comb begin
        state_next = state;
        start_rec  = 1'b0;
        start_play = 1'b0;
        advance    = 1'b0;
        load_entry = 1'b0;
        ram_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cmd_stop) begin
                    state_next = ST_IDLE;
                end else if (cmd_rec) begin
                    start_rec  = 1'b1;
                    state_next = ST_REC;
                end else if (cmd_play && (rec_count != '0)) begin
                    start_play = 1'b1;
                    state_next = ST_FETCH;
                end
            end
            ST_REC: begin
                if (cmd_stop) begin
                    ram_we     = (dur != '0);
                    state_next = ST_IDLE;
                end else if (live_chg || dur_sat) begin
                    // One write covers a change and a saturation in the same cycle.
                    ram_we = 1'b1;
                    if (rec_last) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_FETCH, ST_PLAY: begin
                if (cmd_stop) begin
                    state_next = ST_IDLE;
                end else if (cmd_rec) begin
                    start_rec  = 1'b1;
                    state_next = ST_REC;
                end else if (cmd_play) begin
                    start_play = 1'b1;
                    state_next = ST_FETCH;
                end else if (state == ST_FETCH) begin
                    // First FETCH cycle presents the address, second sees the data.
                    if (fetch_wait) begin
                        load_entry = 1'b1;
                        state_next = ST_PLAY;
                    end
                end else if (play_done) begin
                    if (has_next) begin
                        advance    = 1'b1;
                        state_next = ST_FETCH;
                    end else if (loop_en) begin
                        start_play = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Tick prescaler; restarting at each fetch lets the two FETCH cycles count toward the entry time.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
        end else if (start_rec || start_play || advance || tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PRESC_W'(1);
        end
    end

    // Recording datapath: current event, its duration and the entry count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_octave <= '0;
            cur_note   <= NOTE_REST;
            dur        <= '0;
            rec_count  <= '0;
            full       <= 1'b0;
        end else if (start_rec) begin
            cur_octave <= live_octave;
            cur_note   <= live_note;
            dur        <= '0;
            rec_count  <= '0;
            full       <= 1'b0;
        end else if (state == ST_REC) begin
            if (ram_we) begin
                rec_count  <= rec_count + CNT_W'(1);
                full       <= rec_last;
                cur_octave <= live_octave;
                cur_note   <= live_note;
                dur        <= '0;
            end else if (tick) begin
                dur <= dur + DUR_W'(1);
            end
        end
    end

    // Playback datapath: read index, fetch phase and remaining ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_idx     <= '0;
            fetch_wait <= 1'b0;
            rem        <= '0;
        end else begin
            if (start_play) begin
                rd_idx <= '0;
            end else if (advance) begin
                rd_idx <= rd_idx + ADDR_W'(1);
            end

            if (start_play || advance) begin
                fetch_wait <= 1'b0;
            end else if (state == ST_FETCH) begin
                fetch_wait <= 1'b1;
            end

            if (load_entry) begin
                rem <= ram_rdata[DUR_W-1:0];
            end else if ((state == ST_PLAY) && tick && (rem != '0)) begin
                rem <= rem - DUR_W'(1);
            end
        end
    end

    // Amplifier outputs: live keys (1-cycle latency) outside playback, held through FETCH.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_octave <= '0;
            out_note   <= NOTE_REST;
        end else if (load_entry) begin
            out_octave <= ram_rdata[OCT_LSB +: OCT_W];
            out_note   <= ram_rdata[NOTE_LSB +: NOTE_W];
        end else if ((state == ST_IDLE) || (state == ST_REC)) begin
            out_octave <= live_octave;
            out_note   <= live_note;
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Self-checking bench for note_sequencer (ADDR_W=3, DUR_W=4, TICK_DIV=4).
// Reference model: recordings are described as segments of held keys measured
// in ticks; expected entries and playback runs are derived from those segments.
module tb_note_sequencer;

    localparam int ADDR_W   = 3;
    localparam int DUR_W    = 4;
    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 8;
    localparam int DUR_MAX  = 15;
    localparam logic [5:0] PLAY_LIVE = 6'o77;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       live_octave;
    logic [2:0]       live_note;
    logic             cmd_rec;
    logic             cmd_play;
    logic             cmd_stop;
    logic             loop_en;
    logic [2:0]       out_octave;
    logic [2:0]       out_note;
    logic [1:0]       mode;
    logic [ADDR_W:0]  rec_count;
    logic             full;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected RAM contents and the segments that produce them.
    logic [5:0] exp_key_q[$];
    int         exp_dur_q[$];
    logic [5:0] seg_key_q[$];
    int         seg_tick_q[$];

    note_sequencer #(
        .ADDR_W   (ADDR_W),
        .DUR_W    (DUR_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .live_octave (live_octave),
        .live_note   (live_note),
        .cmd_rec     (cmd_rec),
        .cmd_play    (cmd_play),
        .cmd_stop    (cmd_stop),
        .loop_en     (loop_en),
        .out_octave  (out_octave),
        .out_note    (out_note),
        .mode        (mode),
        .rec_count   (rec_count),
        .full        (full)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance n clocks; the bench always acts 1 ns after a rising edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic r, input logic p, input logic s);
        cmd_rec  = r;
        cmd_play = p;
        cmd_stop = s;
        cyc(1);
        cmd_rec  = 1'b0;
        cmd_play = 1'b0;
        cmd_stop = 1'b0;
    endtask

    task automatic set_live(input logic [5:0] k);
        {live_octave, live_note} = k;
    endtask

    // A key held n ticks becomes full 15-tick entries plus a remainder; nothing beyond DEPTH is kept.
    task automatic model_seg(input logic [5:0] k, input int n);
        int left;
        int d;
        left = n;
        while (left > 0) begin
            d = (left >= DUR_MAX) ? DUR_MAX : left;
            if (exp_key_q.size() < DEPTH) begin
                exp_key_q.push_back(k);
                exp_dur_q.push_back(d);
            end
            left -= d;
        end
    endtask

    // Record the segments in seg_*_q (each held an exact number of ticks), then stop.
    task automatic record_take();
        exp_key_q.delete();
        exp_dur_q.delete();
        set_live(seg_key_q[0]);
        cmd(1'b1, 1'b0, 1'b0);
        check("rec_enter", 32'(mode), 32'd1);
        for (int i = 0; i < seg_key_q.size(); i++) begin
            model_seg(seg_key_q[i], seg_tick_q[i]);
            cyc(TICK_DIV * seg_tick_q[i]);
            if (i + 1 < seg_key_q.size()) set_live(seg_key_q[i + 1]);
            else cmd(1'b0, 1'b0, 1'b1);
        end
        check("rec_mode", 32'(mode), 32'd0);
        check("rec_count", 32'(rec_count), 32'(exp_key_q.size()));
        check("rec_full", 32'(full), 32'(exp_key_q.size() == DEPTH));
    endtask

    // Play once (no loop) and compare the observed output runs with the model.
    task automatic play_check();
        logic [5:0] run_key[$];
        int         run_len[$];
        int         run_ne[$];
        logic [5:0] obs_key[$];
        int         obs_len[$];
        logic [5:0] s;
        logic [5:0] prev;
        int         total;
        int         n;
        int         lo;
        int         hi;
        int         got;
        bit         done;
        total = 0;
        for (int i = 0; i < exp_key_q.size(); i++) begin
            total += exp_dur_q[i];
            if (run_key.size() > 0 && run_key[run_key.size() - 1] == exp_key_q[i]) begin
                run_len[run_len.size() - 1] += TICK_DIV * exp_dur_q[i];
                run_ne[run_ne.size() - 1] += 1;
            end else begin
                run_key.push_back(exp_key_q[i]);
                run_len.push_back(TICK_DIV * exp_dur_q[i]);
                run_ne.push_back(1);
            end
        end
        loop_en = 1'b0;
        set_live(PLAY_LIVE);
        cyc(2);
        cmd(1'b0, 1'b1, 1'b0);
        done = 1'b0;
        n = 0;
        prev = PLAY_LIVE;
        while (!done && n < TICK_DIV * total + 40) begin
            s = {out_octave, out_note};
            if (s != PLAY_LIVE) begin
                if (obs_key.size() > 0 && prev == s) obs_len[obs_len.size() - 1] += 1;
                else begin
                    obs_key.push_back(s);
                    obs_len.push_back(1);
                end
            end
            prev = s;
            if (mode == 2'd0 && s == PLAY_LIVE) done = 1'b1;
            cyc(1);
            n++;
        end
        check("play_end", 32'(done), 32'd1);
        check("run_count", 32'(obs_key.size()), 32'(run_key.size()));
        for (int i = 0; i < obs_key.size() && i < run_key.size(); i++) begin
            check("run_key", 32'(obs_key[i]), 32'(run_key[i]));
            lo  = run_len[i] - 2 * run_ne[i];
            hi  = run_len[i] + 2;
            got = (obs_len[i] >= lo && obs_len[i] <= hi) ? run_len[i] : obs_len[i];
            check("run_len", 32'(got), 32'(run_len[i]));
        end
    endtask

    task automatic add_seg(input logic [5:0] k, input int n);
        seg_key_q.push_back(k);
        seg_tick_q.push_back(n);
    endtask

    initial begin
        logic [5:0] k;
        logic [5:0] last;
        int nseg;
        rst = 1'b1;
        live_octave = '0;
        live_note = '0;
        cmd_rec = 1'b0;
        cmd_play = 1'b0;
        cmd_stop = 1'b0;
        loop_en = 1'b0;

        // Reset state and live passthrough.
        cyc(2);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_out", 32'({out_octave, out_note}), 32'd0);
        check("rst_count", 32'(rec_count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        rst = 1'b0;
        set_live(6'o41);
        cyc(1);
        check("live_out", 32'({out_octave, out_note}), 32'(6'o41));

        // Three-event recording and its playback.
        seg_key_q.delete(); seg_tick_q.delete();
        add_seg(6'o41, 3); add_seg(6'o43, 5); add_seg(6'o40, 2);
        record_take();
        play_check();
        check("play_live", 32'({out_octave, out_note}), 32'(PLAY_LIVE));

        // Looping returns to the first entry after the last one.
        loop_en = 1'b1;
        cmd(1'b0, 1'b1, 1'b0);
        cyc(46);
        check("loop_out", 32'({out_octave, out_note}), 32'(6'o41));
        check("loop_mode", 32'(mode), 32'd2);
        cmd(1'b0, 1'b0, 1'b1);
        check("loop_stop", 32'(mode), 32'd0);
        loop_en = 1'b0;

        // Long note splits into saturated entries.
        seg_key_q.delete(); seg_tick_q.delete();
        add_seg(6'o52, 40);
        record_take();
        play_check();

        // cmd_rec during playback restarts recording.
        cmd(1'b0, 1'b1, 1'b0);
        cyc(10);
        cmd(1'b1, 1'b0, 1'b0);
        check("play_to_rec", 32'(mode), 32'd1);
        cmd(1'b0, 1'b0, 1'b1);
        check("rec_restart_count", 32'(rec_count), 32'd0);

        // Fill the RAM by toggling keys.
        seg_key_q.delete(); seg_tick_q.delete();
        for (int i = 0; i < 10; i++) add_seg((i % 2 == 0) ? 6'o31 : 6'o32, 2);
        record_take();
        play_check();

        // Command collisions, reset mid-play, play with an empty take.
        cmd(1'b0, 1'b1, 1'b0);
        cyc(10);
        cmd(1'b1, 1'b0, 1'b1);
        check("stop_rec_collide", 32'(mode), 32'd0);
        check("collide_count", 32'(rec_count), 32'd8);
        cmd(1'b0, 1'b1, 1'b0);
        cyc(5);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("rst_play_mode", 32'(mode), 32'd0);
        check("rst_play_count", 32'(rec_count), 32'd0);
        check("rst_play_full", 32'(full), 32'd0);
        set_live(PLAY_LIVE);
        cmd(1'b0, 1'b1, 1'b0);
        check("empty_play", 32'(mode), 32'd0);
        cyc(3);
        check("empty_play_out", 32'({out_octave, out_note}), 32'(PLAY_LIVE));

        // Random takes.
        for (int t = 0; t < 6; t++) begin
            seg_key_q.delete(); seg_tick_q.delete();
            nseg = $urandom_range(1, 6);
            last = 6'o77;
            for (int i = 0; i < nseg; i++) begin
                do begin
                    k = {3'($urandom_range(1, 6)), 3'($urandom_range(0, 7))};
                end while (k == last);
                last = k;
                add_seg(k, $urandom_range(1, 35));
            end
            record_take();
            play_check();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
